// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-address sequencer for a simple in-order pipeline.
//
// Holds the current fetch PC and walks it forward by 4 each cycle. Stalls
// freeze it, halts park it, and redirects (exception / branch / jump) load
// a word-aligned target and squash younger instructions for one cycle.
//
// Ports
//   clk              single clock, rising edge
//   reset_n          asynchronous active-low reset
//   i_stall          hold current PC
//   i_branch_taken   redirect to i_branch_target
//   i_branch_target  branch destination
//   i_jump           redirect to i_jump_target
//   i_jump_target    jump destination
//   i_exception      redirect to EXC_VECTOR (highest priority)
//   i_halt           stop fetch
//   o_pc             current fetch address (registered)
//   o_pc_plus4       o_pc + 4, combinational, wraps at 2^32
//   o_valid          o_pc is a valid fetch this cycle (registered)
//   o_flush          squash younger IF/ID instructions (registered)
//   o_state          FSM state
//
// state | meaning
// ------+-----------------------------------------------------------
// BOOT  | first cycle out of reset, PC = RESET_PC, nothing fetched
// RUN   | normal fetch; PC advances by 4 unless stalled
// FLUSH | redirect cycle: PC holds the new target, younger ops squashed
// HALT  | fetch stopped; only an exception leaves this state

module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_stall,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    input  logic        i_jump,
    input  logic [31:0] i_jump_target,
    input  logic        i_exception,
    input  logic        i_halt,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic        o_valid,
    output logic        o_flush,
    output logic [1:0]  o_state
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic        r_valid;
    logic        w_valid_nxt;
    logic        r_flush;
    logic        w_flush_nxt;

    logic        w_redirect;
    logic [31:0] w_target_raw;
    logic [31:0] w_target;
    logic [31:0] w_exc_target;
    logic [31:0] w_pc_plus4;

    assign w_pc_plus4   = r_pc + 32'd4;
    assign w_redirect   = i_exception | i_branch_taken | i_jump;

    // Exception beats branch beats jump; only the winner is ever loaded.
    assign w_target_raw = i_exception    ? EXC_VECTOR      :
                          i_branch_taken ? i_branch_target :
                                           i_jump_target;
    assign w_target     = {w_target_raw[31:2], 2'b00};
    assign w_exc_target = {EXC_VECTOR[31:2], 2'b00};

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = S_BOOT;
        case (r_state)
            S_BOOT:  w_state_nxt = S_RUN;
            S_RUN: begin
                if (w_redirect)  w_state_nxt = S_FLUSH;
                else if (i_halt) w_state_nxt = S_HALT;
                else             w_state_nxt = S_RUN;
            end
            S_FLUSH: w_state_nxt = w_redirect ? S_FLUSH : S_RUN;
            S_HALT:  w_state_nxt = i_exception ? S_FLUSH : S_HALT;
            default: w_state_nxt = S_BOOT;
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        w_pc_nxt    = r_pc;
        w_valid_nxt = 1'b0;
        w_flush_nxt = 1'b0;
        case (r_state)
            S_BOOT: begin
                w_valid_nxt = 1'b1;
            end
            S_RUN: begin
                if (w_redirect) begin
                    w_pc_nxt    = w_target;
                    w_flush_nxt = 1'b1;
                end else if (i_halt) begin
                    w_valid_nxt = 1'b0;
                end else if (i_stall) begin
                    w_valid_nxt = 1'b1;
                end else begin
                    w_pc_nxt    = w_pc_plus4;
                    w_valid_nxt = 1'b1;
                end
            end
            S_FLUSH: begin
                // The target itself is fetched on the first RUN cycle, so the
                // PC is held here rather than advanced.
                if (w_redirect) begin
                    w_pc_nxt    = w_target;
                    w_flush_nxt = 1'b1;
                end else begin
                    w_valid_nxt = 1'b1;
                end
            end
            S_HALT: begin
                if (i_exception) begin
                    w_pc_nxt    = w_exc_target;
                    w_flush_nxt = 1'b1;
                end
            end
            default: begin
                w_pc_nxt = RESET_PC;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc    <= RESET_PC;
            r_valid <= 1'b0;
            r_flush <= 1'b0;
        end else begin
            r_pc    <= w_pc_nxt;
            r_valid <= w_valid_nxt;
            r_flush <= w_flush_nxt;
        end
    end

    assign o_pc       = r_pc;
    assign o_pc_plus4 = w_pc_plus4;
    assign o_valid    = r_valid;
    assign o_flush    = r_flush;
    assign o_state    = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    localparam logic [31:0] P_RESET = 32'h0000_0000;
    localparam logic [31:0] P_EXC   = 32'h0000_0080;

    logic        clk;
    logic        reset_n;
    logic        i_stall;
    logic        i_branch_taken;
    logic [31:0] i_branch_target;
    logic        i_jump;
    logic [31:0] i_jump_target;
    logic        i_exception;
    logic        i_halt;
    logic [31:0] o_pc;
    logic [31:0] o_pc_plus4;
    logic        o_valid;
    logic        o_flush;
    logic [1:0]  o_state;

    int n_tests = 0;
    int n_fail  = 0;

    pc_sequencer #(.RESET_PC(P_RESET), .EXC_VECTOR(P_EXC)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_stall         (i_stall),
        .i_branch_taken  (i_branch_taken),
        .i_branch_target (i_branch_target),
        .i_jump          (i_jump),
        .i_jump_target   (i_jump_target),
        .i_exception     (i_exception),
        .i_halt          (i_halt),
        .o_pc            (o_pc),
        .o_pc_plus4      (o_pc_plus4),
        .o_valid         (o_valid),
        .o_flush         (o_flush),
        .o_state         (o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: fetch mode plus the fetch address, advanced by the
    // written rules once per rising edge.
    int          m_mode;   // 0 boot, 1 run, 2 flush, 3 halt
    logic [31:0] m_pc;
    logic        m_valid;
    logic        m_flush;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    task automatic model_step();
        bit          any_redirect;
        logic [31:0] tgt;
        any_redirect = i_exception || i_branch_taken || i_jump;
        if (i_exception)         tgt = word_align(P_EXC);
        else if (i_branch_taken) tgt = word_align(i_branch_target);
        else                     tgt = word_align(i_jump_target);
        m_flush = 1'b0;
        if (m_mode == 0) begin
            m_mode = 1; m_valid = 1'b1;
        end else if (m_mode == 3) begin
            m_valid = 1'b0;
            if (i_exception) begin
                m_pc = word_align(P_EXC); m_mode = 2; m_flush = 1'b1;
            end
        end else if (any_redirect) begin
            m_pc = tgt; m_mode = 2; m_flush = 1'b1; m_valid = 1'b0;
        end else if (m_mode == 2) begin
            m_mode = 1; m_valid = 1'b1;
        end else if (i_halt) begin
            m_mode = 3; m_valid = 1'b0;
        end else if (i_stall) begin
            m_valid = 1'b1;
        end else begin
            m_pc = m_pc + 32'd4; m_valid = 1'b1;
        end
    endtask

    initial begin
        m_mode = 0; m_pc = P_RESET; m_valid = 1'b0; m_flush = 1'b0;
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode = 0; m_pc = P_RESET; m_valid = 1'b0; m_flush = 1'b0;
        end else begin
            model_step();
        end
        #1;
        chk("model_pc",     o_pc,              m_pc);
        chk("model_plus4",  o_pc_plus4,        m_pc + 32'd4);
        chk("model_valid",  {31'd0, o_valid},  {31'd0, m_valid});
        chk("model_flush",  {31'd0, o_flush},  {31'd0, m_flush});
        chk("model_state",  {30'd0, o_state},  m_mode[31:0]);
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clr_inputs();
        i_stall = 0; i_branch_taken = 0; i_jump = 0; i_exception = 0; i_halt = 0;
        i_branch_target = 32'h0; i_jump_target = 32'h0;
    endtask

    task automatic chk_out(input string name, input logic [31:0] pc, input logic v,
                           input logic f, input logic [1:0] s);
        chk({name, "_pc"},    o_pc,             pc);
        chk({name, "_valid"}, {31'd0, o_valid}, {31'd0, v});
        chk({name, "_flush"}, {31'd0, o_flush}, {31'd0, f});
        chk({name, "_state"}, {30'd0, o_state}, {30'd0, s});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        clr_inputs();
        i_jump = 1; i_jump_target = 32'h0000_0500;   // must be ignored in reset
        #12;
        chk_out("reset", 32'h0, 0, 0, 2'd0);
        step();
        clr_inputs();
        reset_n = 1'b1;
        chk_out("boot", 32'h0, 0, 0, 2'd0);
        i_jump = 1; i_jump_target = 32'h0000_0600;   // ignored in BOOT
        step();
        i_jump = 0;
        chk_out("run0", 32'h0, 1, 0, 2'd1);
        step(); chk_out("run4", 32'h4, 1, 0, 2'd1);
        step(); chk_out("run8", 32'h8, 1, 0, 2'd1);
        step(); chk_out("runC", 32'hC, 1, 0, 2'd1);
        step(); chk("run10", o_pc, 32'h10);

        i_stall = 1;
        step(); chk_out("stall1", 32'h10, 1, 0, 2'd1);
        step(); chk_out("stall2", 32'h10, 1, 0, 2'd1);
        i_stall = 0;
        step(); chk_out("unstall", 32'h14, 1, 0, 2'd1);
        step(); step(); step(); chk("at20", o_pc, 32'h20);

        i_branch_taken = 1; i_branch_target = 32'h0000_0103;
        i_jump = 1; i_jump_target = 32'h0000_0400; i_stall = 1;
        step(); chk_out("br_flush", 32'h100, 0, 1, 2'd2);
        clr_inputs();
        step(); chk_out("br_run", 32'h100, 1, 0, 2'd1);
        step(); chk_out("br_next", 32'h104, 1, 0, 2'd1);

        i_jump = 1; i_jump_target = 32'h0000_0040;
        step(); chk_out("j40_flush", 32'h40, 0, 1, 2'd2);
        clr_inputs();
        step(); chk_out("j40_run", 32'h40, 1, 0, 2'd1);
        i_halt = 1;
        step(); chk_out("halt", 32'h40, 0, 0, 2'd3);
        i_jump = 1; i_jump_target = 32'h0000_0400;
        i_branch_taken = 1; i_branch_target = 32'h0000_0800; i_stall = 1;
        for (int k = 0; k < 5; k++) begin
            step(); chk_out("halt_hold", 32'h40, 0, 0, 2'd3);
        end
        i_exception = 1;
        step(); chk_out("exc_flush", 32'h80, 0, 1, 2'd2);
        clr_inputs();
        step(); chk_out("exc_run", 32'h80, 1, 0, 2'd1);
        step(); chk_out("exc_next", 32'h84, 1, 0, 2'd1);

        i_jump = 1; i_jump_target = 32'h0000_0200;
        step(); chk_out("fr1", 32'h200, 0, 1, 2'd2);
        i_jump = 0; i_branch_taken = 1; i_branch_target = 32'h0000_0501; i_halt = 1;
        step(); chk_out("fr2", 32'h500, 0, 1, 2'd2);
        clr_inputs();
        step(); chk_out("fr_run", 32'h500, 1, 0, 2'd1);

        i_jump = 1; i_jump_target = 32'hFFFF_FFFA;
        step(); chk_out("wrap_flush", 32'hFFFF_FFF8, 0, 1, 2'd2);
        clr_inputs();
        step(); chk_out("wrap_run", 32'hFFFF_FFF8, 1, 0, 2'd1);
        step(); chk("wrap_fc", o_pc, 32'hFFFF_FFFC);
        chk("wrap_plus4", o_pc_plus4, 32'h0);
        step(); chk_out("wrap_zero", 32'h0, 1, 0, 2'd1);

        i_jump = 1; i_jump_target = 32'h0000_0300;
        step(); chk_out("pre_rst_flush", 32'h300, 0, 1, 2'd2);
        clr_inputs();
        #2 reset_n = 1'b0;
        #1 chk_out("async_rst_flush", 32'h0, 0, 0, 2'd0);
        step();
        reset_n = 1'b1;
        chk_out("boot2", 32'h0, 0, 0, 2'd0);
        step(); chk_out("run2", 32'h0, 1, 0, 2'd1);

        i_halt = 1;
        step(); chk_out("halt2", 32'h0, 0, 0, 2'd3);
        #2 reset_n = 1'b0;
        #1 chk_out("async_rst_halt", 32'h0, 0, 0, 2'd0);
        step();
        clr_inputs();
        reset_n = 1'b1;
        chk_out("boot3", 32'h0, 0, 0, 2'd0);
        step(); chk_out("run3", 32'h0, 1, 0, 2'd1);
        step(); chk_out("run3b", 32'h4, 1, 0, 2'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 The module SHALL have parameter EXC_VECTOR, default 32'h0000_0080, PC loaded on exception.
REQ-003 Port clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port i_stall  input  1  hold current PC (pipeline hazard).
REQ-006 Port i_branch_taken  input  1  redirect to i_branch_target.
REQ-007 Port i_branch_target  input  32  branch destination.
REQ-008 Port i_jump  input  1  redirect to i_jump_target.
REQ-009 Port i_jump_target  input  32  jump destination.
REQ-010 Port i_exception  input  1  redirect to EXC_VECTOR.
REQ-011 Port i_halt  input  1  stop fetch.
REQ-012 Port o_pc  output  32  current fetch address (registered).
REQ-013 Port o_pc_plus4  output  32  o_pc + 4, combinational.
REQ-014 Port o_valid  output  1  o_pc is a valid fetch this cycle (registered).
REQ-015 Port o_flush  output  1  squash younger IF/ID instructions (registered).
REQ-016 Port o_state  output  2  FSM state: 0 BOOT, 1 RUN, 2 FLUSH, 3 HALT.

Function
REQ-017 o_pc_plus4 SHALL be a 32-bit sum of o_pc and 32'd4, carry discarded; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-018 Every PC load from a target SHALL force bits [1:0] to 2'b00.
REQ-019 Redirect priority SHALL be i_exception > i_branch_taken > i_jump; only the highest asserted source is used.
REQ-020 BOOT: o_valid=0, o_pc=RESET_PC; next cycle -> RUN unconditionally, PC unchanged.
REQ-021 RUN, any redirect asserted: o_pc <= selected target, o_flush <= 1, o_valid <= 0, -> FLUSH; redirect overrides i_stall and i_halt.
REQ-022 RUN, no redirect, i_halt=1: o_pc held, o_valid <= 0, -> HALT.
REQ-023 RUN, no redirect, i_halt=0, i_stall=1: o_pc held, o_valid held at 1, stays RUN.
REQ-024 RUN, no inputs asserted: o_pc <= o_pc_plus4, o_valid=1, stays RUN.
REQ-025 FLUSH: lasts exactly one cycle; o_flush=1, o_valid=0, o_pc holds target; next -> RUN with o_flush <= 0, o_valid <= 1.
REQ-026 FLUSH with a new redirect: new target loaded, stays FLUSH one more cycle (o_flush remains 1); i_stall and i_halt ignored in FLUSH.
REQ-027 HALT: o_pc held, o_valid=0; only i_exception exits (loads EXC_VECTOR, -> FLUSH); branch/jump/stall ignored.
REQ-028 o_flush SHALL be 1 only in FLUSH, never two-plus cycles without a redirect each cycle.
REQ-029 Unused state encodings SHALL recover to BOOT on the next edge.

Reset
REQ-030 reset_n=0 SHALL immediately (no clock) force o_pc=RESET_PC, o_valid=0, o_flush=0, o_state=BOOT.
REQ-031 Reset asserted mid-FLUSH or mid-HALT SHALL abort it; first cycle after release is BOOT.
REQ-032 Inputs SHALL have no effect while reset_n=0 or in the BOOT cycle.

Verification
REQ-033 Release reset, no inputs, 4 cycles -> o_pc 0x0,0x0(BOOT),0x4,0x8,0xC; o_valid 0,1,1,1 after BOOT.
REQ-034 In RUN at 0x10, i_stall 2 cycles -> o_pc stays 0x10 two cycles, then 0x14; o_valid stays 1.
REQ-035 At 0x20, i_branch_taken=1 target 0x103 with i_jump=1 target 0x400 and i_stall=1 -> o_pc=0x100, o_flush=1 one cycle, o_valid=0, then 0x104 with o_valid=1.
REQ-036 i_halt at 0x40 -> HALT, o_pc=0x40 held 5 cycles despite i_jump; then i_exception -> o_pc=0x80, FLUSH, then 0x84.
REQ-037 Force o_pc to 0xFFFF_FFF8 via jump -> sequence 0xFFFF_FFFC, 0x0000_0000; o_pc_plus4 at 0xFFFF_FFFC reads 0x0.
REQ-038 Assert reset_n=0 between clock edges during FLUSH -> outputs reset asynchronously to 0x0/0/0/BOOT before next edge.
